// File: rtl/interp_ctrl_mc_pkg.sv
// Shared definitions for the multi-channel polyphase interpolator control slice.
// Holds the sequencer state encoding and a width helper used by the other files.
package interp_ctrl_mc_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Number of bits needed to hold values 0..n-1, never less than 1.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/interp_ctrl_mc_ctrl_delay_line.sv
// ctrl_delay_line: fixed-depth shift register used to align control tags with
// the RAM + multiplier pipeline.
// Ports:
//   Clk_i  - clock
//   Rst_i  - asynchronous active-high reset, clears every stage to 0
//   i_data - value entering the line
//   o_data - value that entered Depth cycles earlier
module ctrl_delay_line #(
  parameter int Depth = 1,
  parameter int Width = 1
) (
  input  logic             Clk_i,
  input  logic             Rst_i,
  input  logic [Width-1:0] i_data,
  output logic [Width-1:0] o_data
);

  logic [Width-1:0] r_pipe [Depth];

  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      for (int i = 0; i < Depth; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_data;
      for (int i = 1; i < Depth; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_data = r_pipe[Depth-1];

endmodule

// File: rtl/interp_ctrl_mc.sv
// interp_ctrl_mc: control sequencer for a single-MAC polyphase interpolator.
// Each accepted sample is written into its channel's circular buffer, then
// InterpolationK phases of FilterLength/InterpolationK taps are read out,
// one read per cycle, with MAC load/valid tags aligned to the pipeline.
//
// Handshake: a sample is taken in any cycle where DataNd_i and Ready_o are
// both high and DataCh_i names an existing channel; Ready_o is combinational
// and does not depend on DataNd_i. A strobe that is not taken is lost and
// sets the sticky Overrun_o.
//
// Ports:
//   Clk_i, Rst_i          - clock, asynchronous active-high reset
//   DataNd_i, DataCh_i    - sample strobe and its channel
//   Ready_o               - sequencer can take a sample this cycle
//   DataWe_o/DataAddrWr_o - data RAM write for the accepted sample
//   DataAddr_o            - data RAM read address {ch, ptr}
//   CoeffAddr_o           - coefficient ROM address
//   StartAcc_o            - MAC loads instead of accumulating
//   DataValid_o, DataCh_o - completed phase result and its channel
//   Overrun_o             - sticky dropped-sample flag
//   DbgState_o            - current sequencer state
module interp_ctrl_mc
  import interp_ctrl_mc_pkg::*;
#(
  parameter int FilterLength   = 16,
  parameter int InterpolationK = 2,
  parameter int NumChannels    = 2,
  parameter int ChW            = 1,
  parameter int DataAddrWidth  = 4,
  parameter int CoeffAddrWidth = 4,
  parameter int PipeDelay      = 2
) (
  input  logic                              Clk_i,
  input  logic                              Rst_i,
  input  logic                              DataNd_i,
  input  logic [ChW-1:0]                    DataCh_i,
  output logic                              Ready_o,
  output logic                              DataWe_o,
  output logic [ChW+DataAddrWidth-1:0]      DataAddrWr_o,
  output logic [ChW+DataAddrWidth-1:0]      DataAddr_o,
  output logic [CoeffAddrWidth-1:0]         CoeffAddr_o,
  output logic                              StartAcc_o,
  output logic                              DataValid_o,
  output logic [ChW-1:0]                    DataCh_o,
  output logic                              Overrun_o,
  output state_t                            DbgState_o
);

  localparam int TP = FilterLength / InterpolationK;
  localparam int TW = clog2_min1(TP);
  localparam int PW = clog2_min1(InterpolationK);

  state_t                     r_state;
  logic [TW-1:0]              r_tap;
  logic [PW-1:0]              r_phase;
  logic [ChW-1:0]             r_cur_ch;
  logic [DataAddrWidth-1:0]   r_base;
  logic [DataAddrWidth-1:0]   r_wr_ptr [NumChannels];
  logic [ChW+DataAddrWidth-1:0] r_data_addr;
  logic [CoeffAddrWidth-1:0]  r_coeff_addr;
  logic                       r_overrun;

  logic                       w_ch_ok;
  logic                       w_tap_last;
  logic                       w_phase_last;
  logic                       w_ready;
  logic                       w_accept;
  logic                       w_drop;
  logic [DataAddrWidth-1:0]   w_wr_ptr;
  logic [TW-1:0]              w_next_tap;
  logic [PW-1:0]              w_next_phase;
  logic                       w_first;
  logic                       w_last;
  logic [ChW:0]               w_last_dly;

  assign w_ch_ok      = int'(DataCh_i) < NumChannels;
  assign w_tap_last   = (r_tap == TW'(TP - 1));
  assign w_phase_last = (r_phase == PW'(InterpolationK - 1));

  // Ready also in the final read cycle so consecutive samples run bubble-free.
  // Held low while reset is asserted so every output reads 0 in reset.
  assign w_ready  = !Rst_i &&
                    ((r_state == ST_IDLE) ||
                     ((r_state == ST_RUN) && w_tap_last && w_phase_last));
  assign w_accept = DataNd_i && w_ready && w_ch_ok;
  assign w_drop   = DataNd_i && !w_accept && !Rst_i;

  // Write pointer of the strobed channel (0 for a non-existent channel).
  always_comb begin
    w_wr_ptr = '0;
    for (int c = 0; c < NumChannels; c++) begin
      if (DataCh_i == ChW'(c)) w_wr_ptr = r_wr_ptr[c];
    end
  end

  assign w_next_tap   = w_tap_last ? '0 : r_tap + 1'b1;
  assign w_next_phase = w_tap_last ? r_phase + 1'b1 : r_phase;

  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      r_state      <= ST_IDLE;
      r_tap        <= '0;
      r_phase      <= '0;
      r_cur_ch     <= '0;
      r_base       <= '0;
      r_data_addr  <= '0;
      r_coeff_addr <= '0;
      r_overrun    <= 1'b0;
      for (int c = 0; c < NumChannels; c++) r_wr_ptr[c] <= '0;
    end else begin
      if (w_accept) begin
        for (int c = 0; c < NumChannels; c++) begin
          if (DataCh_i == ChW'(c)) r_wr_ptr[c] <= r_wr_ptr[c] + 1'b1;
        end
        r_base       <= w_wr_ptr;
        r_cur_ch     <= DataCh_i;
        r_tap        <= '0;
        r_phase      <= '0;
        r_state      <= ST_RUN;
        // First read of a sample is the sample just written (base - 0).
        r_data_addr  <= {DataCh_i, w_wr_ptr};
        r_coeff_addr <= '0;
      end else if (r_state == ST_RUN) begin
        if (w_tap_last && w_phase_last) begin
          r_state <= ST_IDLE;
        end else begin
          r_tap        <= w_next_tap;
          r_phase      <= w_next_phase;
          r_data_addr  <= {r_cur_ch, r_base - DataAddrWidth'(w_next_tap)};
          r_coeff_addr <= CoeffAddrWidth'(int'(w_next_phase) +
                                          int'(w_next_tap) * InterpolationK);
        end
      end
      if (w_drop) r_overrun <= 1'b1;
    end
  end

  assign w_first = (r_state == ST_RUN) && (r_tap == '0);
  assign w_last  = (r_state == ST_RUN) && w_tap_last;

  ctrl_delay_line #(
    .Depth (PipeDelay),
    .Width (1)
  ) u_first_dly (
    .Clk_i  (Clk_i),
    .Rst_i  (Rst_i),
    .i_data (w_first),
    .o_data (StartAcc_o)
  );

  // One stage longer than the load tag: the result is ready the cycle after
  // the last product has been accumulated.
  ctrl_delay_line #(
    .Depth (PipeDelay + 1),
    .Width (ChW + 1)
  ) u_last_dly (
    .Clk_i  (Clk_i),
    .Rst_i  (Rst_i),
    .i_data ({w_last, r_cur_ch}),
    .o_data (w_last_dly)
  );

  assign DataValid_o  = w_last_dly[ChW];
  assign DataCh_o     = w_last_dly[ChW-1:0];
  assign Ready_o      = w_ready;
  assign DataWe_o     = w_accept;
  assign DataAddrWr_o = w_accept ? {DataCh_i, w_wr_ptr} : '0;
  assign DataAddr_o   = r_data_addr;
  assign CoeffAddr_o  = r_coeff_addr;
  assign Overrun_o    = r_overrun;
  assign DbgState_o   = r_state;

endmodule
